// File: rtl/latency_monitor_pkg.sv
// Shared widths and FSM encoding for the per-core latency monitor.
package latency_monitor_pkg;

   localparam int DEF_TIME_WIDTH = 16;
   localparam int DEF_CNT_WIDTH  = 16;
   localparam int DEF_SUM_WIDTH  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/latency_monitor_if.sv
// Receive-side handshake, timestamp and statistics bundle between a NI and its latency monitor.
interface latency_monitor_if
   import latency_monitor_pkg::*;
#(
   parameter int TIME_WIDTH = DEF_TIME_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int SUM_WIDTH  = DEF_SUM_WIDTH
);

   logic                  enable_global;
   logic [TIME_WIDTH-1:0] counter_num;
   logic [CNT_WIDTH-1:0]  expect_pkts;
   logic                  rx_valid;
   logic [TIME_WIDTH-1:0] rx_timestamp;
   logic                  rx_ready;
   logic                  lat_valid;
   logic [TIME_WIDTH-1:0] lat_value;
   logic [CNT_WIDTH-1:0]  pkt_count;
   logic [SUM_WIDTH-1:0]  lat_sum;
   logic [TIME_WIDTH-1:0] lat_max;
   logic [TIME_WIDTH-1:0] lat_min;
   logic                  receive_finish_flag;

   modport master (
      output enable_global, counter_num, expect_pkts, rx_valid, rx_timestamp,
      input  rx_ready, lat_valid, lat_value, pkt_count, lat_sum, lat_max, lat_min,
             receive_finish_flag
   );

   modport slave (
      input  enable_global, counter_num, expect_pkts, rx_valid, rx_timestamp,
      output rx_ready, lat_valid, lat_value, pkt_count, lat_sum, lat_max, lat_min,
             receive_finish_flag
   );

endinterface

// File: rtl/latency_monitor_gray2bin.sv
// Gray to binary decoder: each binary bit is the XOR of all Gray bits at or above it.
// Latency: combinational.
// Backpressure: none.
module latency_monitor_gray2bin #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/latency_monitor.sv
// Per-core latency monitor: decodes Gray timestamps, accumulates count/sum/min/max, raises finish flag.
// Latency: lat_valid two edges after accept; finish flag one edge after the last retirement.
// Backpressure: rx_ready drops when paused, outside RUN, or once all expected packets are accepted.
module latency_monitor
   import latency_monitor_pkg::*;
#(
   parameter int TIME_WIDTH = DEF_TIME_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
   input logic             clk_global,
   input logic             rst,
   latency_monitor_if.slave mon
);

   state_t state, next_state;

   logic [CNT_WIDTH-1:0]  exp_q;
   logic [CNT_WIDTH-1:0]  acc_cnt;
   logic                  rx_ready_c;
   logic                  accept;
   logic                  retire_done;

   logic [TIME_WIDTH-1:0] now_bin, inj_bin;
   logic [TIME_WIDTH-1:0] now_q, inj_q, diff_q;
   logic                  s1_vld, s2_vld;

   logic                  lat_valid_q;
   logic [TIME_WIDTH-1:0] lat_value_q;
   logic [CNT_WIDTH-1:0]  pkt_count_q;
   logic [SUM_WIDTH-1:0]  lat_sum_q;
   logic [TIME_WIDTH-1:0] lat_max_q, lat_min_q;
   logic                  finish_q;
   logic [SUM_WIDTH:0]    sum_ext;

   latency_monitor_gray2bin #(.WIDTH(TIME_WIDTH)) u_now_dec (
      .gray (mon.counter_num),
      .bin  (now_bin)
   );

   latency_monitor_gray2bin #(.WIDTH(TIME_WIDTH)) u_inj_dec (
      .gray (mon.rx_timestamp),
      .bin  (inj_bin)
   );

   assign accept      = mon.rx_valid && rx_ready_c;
   assign retire_done = (pkt_count_q == exp_q) && !s1_vld && !s2_vld;

   always_ff @(posedge clk_global) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (mon.enable_global) begin
               next_state = (mon.expect_pkts == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (retire_done) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      rx_ready_c = (state == RUN) && mon.enable_global && (acc_cnt < exp_q);
   end

   always_ff @(posedge clk_global) begin
      if (rst) begin
         exp_q   <= '0;
         acc_cnt <= '0;
      end else begin
         if (state == IDLE && mon.enable_global) begin
            exp_q <= mon.expect_pkts;
         end
         if (accept) begin
            acc_cnt <= acc_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // Modular subtract absorbs a single counter wrap between injection and now.
   always_ff @(posedge clk_global) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         now_q  <= '0;
         inj_q  <= '0;
         diff_q <= '0;
      end else begin
         s1_vld <= accept;
         s2_vld <= s1_vld;
         if (accept) begin
            now_q <= now_bin;
            inj_q <= inj_bin;
         end
         if (s1_vld) begin
            diff_q <= now_q - inj_q;
         end
      end
   end

   assign sum_ext = {1'b0, lat_sum_q} + {{(SUM_WIDTH + 1 - TIME_WIDTH){1'b0}}, diff_q};

   always_ff @(posedge clk_global) begin
      if (rst) begin
         lat_valid_q <= 1'b0;
         lat_value_q <= '0;
         pkt_count_q <= '0;
         lat_sum_q   <= '0;
         lat_max_q   <= '0;
         lat_min_q   <= '1;
      end else begin
         lat_valid_q <= s2_vld;
         if (s2_vld) begin
            lat_value_q <= diff_q;
            pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
            lat_sum_q   <= sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
            if (diff_q > lat_max_q) lat_max_q <= diff_q;
            if (diff_q < lat_min_q) lat_min_q <= diff_q;
         end
      end
   end

   // Set alongside the RUN->DONE edge; the DONE term covers the zero-packet path one edge later.
   always_ff @(posedge clk_global) begin
      if (rst) begin
         finish_q <= 1'b0;
      end else begin
         finish_q <= finish_q || (state == DONE) || (state == RUN && retire_done);
      end
   end

   assign mon.rx_ready            = rx_ready_c;
   assign mon.lat_valid           = lat_valid_q;
   assign mon.lat_value           = lat_value_q;
   assign mon.pkt_count           = pkt_count_q;
   assign mon.lat_sum             = lat_sum_q;
   assign mon.lat_max             = lat_max_q;
   assign mon.lat_min             = lat_min_q;
   assign mon.receive_finish_flag = finish_q;

endmodule

// File: tb/tb_latency_monitor.sv
// Directed bench for latency_monitor with a latency/arrival-cycle scoreboard.
module tb_latency_monitor;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   latency_monitor_if #(.TIME_WIDTH(16), .CNT_WIDTH(16), .SUM_WIDTH(32)) bus ();

   latency_monitor #(.TIME_WIDTH(16), .CNT_WIDTH(16), .SUM_WIDTH(32)) dut (
      .clk_global (clk),
      .rst        (rst),
      .mon        (bus)
   );

   typedef struct {
      logic [15:0] lat;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

   // Every lat_valid strobe must match the oldest expected latency and arrival cycle.
   always @(negedge clk) begin
      if (bus.lat_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_lat_valid", {31'b0, bus.lat_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("lat_value", {16'b0, bus.lat_value}, {16'b0, e.lat});
            chk("lat_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_reset();
      bus.enable_global = 1'b0;
      bus.rx_valid      = 1'b0;
      bus.expect_pkts   = '0;
      bus.counter_num   = '0;
      bus.rx_timestamp  = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start(input logic [15:0] n);
      bus.expect_pkts   = n;
      bus.enable_global = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive(input logic [15:0] now, input logic [15:0] inj, input bit expect_out);
      exp_t e;
      bus.counter_num  = gray(now);
      bus.rx_timestamp = gray(inj);
      bus.rx_valid     = 1'b1;
      #1;
      chk("rx_ready_at_accept", {31'b0, bus.rx_ready}, 32'd1);
      if (expect_out) begin
         e.lat = now - inj;
         e.cyc = cyc + 3;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic finish_check(input int cnt, input int sum, input int mn, input int mx);
      repeat (2) @(negedge clk);
      chk("pkt_count", {16'b0, bus.pkt_count}, cnt);
      chk("lat_sum", bus.lat_sum, sum);
      chk("lat_min", {16'b0, bus.lat_min}, mn);
      chk("lat_max", {16'b0, bus.lat_max}, mx);
      chk("flag_before", {31'b0, bus.receive_finish_flag}, 32'd0);
      @(negedge clk);
      chk("flag_after", {31'b0, bus.receive_finish_flag}, 32'd1);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_lat_valid", {31'b0, bus.lat_valid}, 32'd0);
      chk("rst_lat_value", {16'b0, bus.lat_value}, 32'd0);
      chk("rst_pkt_count", {16'b0, bus.pkt_count}, 32'd0);
      chk("rst_lat_sum", bus.lat_sum, 32'd0);
      chk("rst_lat_max", {16'b0, bus.lat_max}, 32'd0);
      chk("rst_lat_min", {16'b0, bus.lat_min}, 32'h0000_FFFF);
      chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
      chk("rst_flag", {31'b0, bus.receive_finish_flag}, 32'd0);

      // Single packet: now 100, injected 40
      start(16'd1);
      drive(16'd100, 16'd40, 1'b1);
      bus.rx_valid = 1'b0;
      #1;
      chk("single_rx_ready_drop", {31'b0, bus.rx_ready}, 32'd0);
      finish_check(1, 60, 60, 60);

      // Counter wrap: injected 65530, now 4
      do_reset();
      start(16'd1);
      drive(16'd4, 16'd65530, 1'b1);
      bus.rx_valid = 1'b0;
      finish_check(1, 10, 10, 10);

      // Burst of four back-to-back packets: 5, 9, 2, 7
      do_reset();
      start(16'd4);
      drive(16'd1005, 16'd1000, 1'b1);
      drive(16'd1010, 16'd1001, 1'b1);
      drive(16'd1002, 16'd1000, 1'b1);
      drive(16'd1010, 16'd1003, 1'b1);
      bus.rx_valid = 1'b0;
      #1;
      chk("burst_rx_ready_drop", {31'b0, bus.rx_ready}, 32'd0);
      finish_check(4, 23, 2, 9);

      // Pause with one packet in flight; NI keeps the next packet presented
      do_reset();
      start(16'd3);
      drive(16'd200, 16'd189, 1'b1);
      bus.enable_global = 1'b0;
      bus.rx_valid      = 1'b1;
      bus.counter_num   = gray(16'd300);
      bus.rx_timestamp  = gray(16'd280);
      #1;
      chk("pause_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
      repeat (2) @(negedge clk);
      chk("pause_retired", {16'b0, bus.pkt_count}, 32'd1);
      repeat (2) @(negedge clk);
      chk("pause_no_accept", {16'b0, bus.pkt_count}, 32'd1);
      chk("pause_flag", {31'b0, bus.receive_finish_flag}, 32'd0);
      bus.enable_global = 1'b1;
      drive(16'd300, 16'd280, 1'b1);
      drive(16'd310, 16'd307, 1'b1);
      bus.rx_valid = 1'b0;
      finish_check(3, 34, 3, 20);

      // Reset one edge after an accept flushes the pipeline
      do_reset();
      start(16'd2);
      drive(16'd500, 16'd450, 1'b0);
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("flush_pkt_count", {16'b0, bus.pkt_count}, 32'd0);
      chk("flush_lat_valid", {31'b0, bus.lat_valid}, 32'd0);
      chk("flush_idle_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
      chk("flush_lat_min", {16'b0, bus.lat_min}, 32'h0000_FFFF);
      repeat (4) @(negedge clk);
      chk("flush_pkt_count_late", {16'b0, bus.pkt_count}, 32'd0);
      chk("flush_flag", {31'b0, bus.receive_finish_flag}, 32'd0);

      // Zero expected packets: flag one edge after IDLE->DONE
      do_reset();
      start(16'd0);
      chk("zero_flag_before", {31'b0, bus.receive_finish_flag}, 32'd0);
      chk("zero_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
      @(negedge clk);
      chk("zero_flag_after", {31'b0, bus.receive_finish_flag}, 32'd1);

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
